// File: rtl/ble_packet_unloader_if.sv
// rtl/ble_packet_unloader_if.sv - byte stream interface from the packet unloader to the readout sink
// Carries one over-the-air byte per handshake; m_last flags the final byte of a packet.
interface ble_packet_unloader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/ble_packet_unloader.sv
// rtl/ble_packet_unloader.sv - unloads a captured BLE packet vector as an LSB-first byte stream
// Synchronises packet_detected, checks the length, parses the PDU header and keeps drop/error counters.
module ble_packet_unloader #(
  parameter int PACKET_LEN_MAX = 376,
  parameter int PREAMBLE_LEN   = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_en,
  input  logic                                     i_packet_detected,
  input  logic [PACKET_LEN_MAX-PREAMBLE_LEN-1:0]   i_packet_out,
  input  logic [8:0]                               i_packet_len,
  ble_packet_unloader_if.master                    m_if,
  output logic                                     o_busy,
  output logic [3:0]                               o_pdu_type,
  output logic [7:0]                               o_pdu_len,
  output logic                                     o_hdr_len_err,
  output logic [CNT_WIDTH-1:0]                     o_drop_count,
  output logic [CNT_WIDTH-1:0]                     o_err_count
);

  localparam int W        = PACKET_LEN_MAX - PREAMBLE_LEN;
  localparam int MIN_BITS = 72;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]           r_state;
  logic                 r_s1, r_s2, r_s3;
  logic [W-1:0]         r_buf;
  logic [8:0]           r_n;
  logic [5:0]           r_byte_idx;
  logic [3:0]           r_pdu_type;
  logic [7:0]           r_pdu_len;
  logic                 r_hdr_len_err;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic                 w_rise;
  logic [8:0]           w_n;
  logic                 w_legal;
  logic [W-1:0]         w_aligned;
  logic [7:0]           w_cur;
  logic [7:0]           w_b4;
  logic [7:0]           w_b5;
  logic [5:0]           w_nbytes;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_hs;
  logic                 w_drop;
  logic                 w_err;

  assign w_rise   = r_s2 & ~r_s3;
  assign w_n      = i_packet_len - 9'(PREAMBLE_LEN);
  assign w_legal  = (w_n[2:0] == 3'b000) && (w_n >= 9'(MIN_BITS)) && (w_n <= 9'(W));
  assign w_aligned = r_buf << (9'(W) - r_n);
  assign w_nbytes = r_n[8:3];
  assign w_valid  = (r_state == S_SEND);
  assign w_last   = (r_byte_idx == (w_nbytes - 6'd1));
  assign w_hs     = w_valid & m_if.m_ready;
  assign w_drop   = w_rise & ((r_state != S_IDLE) | ~i_en);
  assign w_err    = w_rise & (r_state == S_IDLE) & i_en & ~w_legal;

  // The buffer is kept left-aligned and shifted by a byte per handshake, so the
  // current byte always sits in the top 8 bits, oldest bit first.
  always_comb begin
    w_cur = '0;
    w_b4  = '0;
    w_b5  = '0;
    for (int j = 0; j < 8; j++) begin
      w_cur[j] = r_buf[W-1-j];
      w_b4[j]  = w_aligned[W-33-j];
      w_b5[j]  = w_aligned[W-41-j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_buf         <= '0;
      r_n           <= '0;
      r_byte_idx    <= '0;
      r_pdu_type    <= '0;
      r_pdu_len     <= '0;
      r_hdr_len_err <= 1'b0;
      r_drop_count  <= '0;
      r_err_count   <= '0;
    end else begin
      r_s1 <= i_packet_detected;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}}))
        r_drop_count <= r_drop_count + 1'b1;
      if (w_err && (r_err_count != {CNT_WIDTH{1'b1}}))
        r_err_count <= r_err_count + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_rise && i_en && w_legal) begin
            r_buf   <= i_packet_out;
            r_n     <= w_n;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_buf         <= w_aligned;
          r_pdu_type    <= w_b4[3:0];
          r_pdu_len     <= w_b5;
          r_hdr_len_err <= (w_b5 != (8'(w_nbytes) - 8'd9));
          r_byte_idx    <= '0;
          r_state       <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_buf      <= r_buf << 8;
            r_byte_idx <= r_byte_idx + 6'd1;
            if (w_last)
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_if.m_valid = w_valid;
  assign m_if.m_data  = w_valid ? w_cur : 8'h00;
  assign m_if.m_last  = w_valid & w_last;

  assign o_busy        = (r_state != S_IDLE);
  assign o_pdu_type    = r_pdu_type;
  assign o_pdu_len     = r_pdu_len;
  assign o_hdr_len_err = r_hdr_len_err;
  assign o_drop_count  = r_drop_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_ble_packet_unloader.sv
// tb/tb_ble_packet_unloader.sv - scoreboard bench for ble_packet_unloader
// Directed packets are pushed as expected bytes; a negedge monitor pops and compares every handshake.
module tb_ble_packet_unloader;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         pd  = 1'b0;
  logic [367:0] pout = '0;
  logic [8:0]   plen = '0;
  logic         busy;
  logic [3:0]   pdu_type;
  logic [7:0]   pdu_len;
  logic         hdr_err;
  logic [7:0]   drop_cnt;
  logic [7:0]   err_cnt;

  ble_packet_unloader_if bus();

  ble_packet_unloader dut (
    .clk               (clk),
    .rst               (rst),
    .i_en              (en),
    .i_packet_detected (pd),
    .i_packet_out      (pout),
    .i_packet_len      (plen),
    .m_if              (bus),
    .o_busy            (busy),
    .o_pdu_type        (pdu_type),
    .o_pdu_len         (pdu_len),
    .o_hdr_len_err     (hdr_err),
    .o_drop_count      (drop_cnt),
    .o_err_count       (err_cnt)
  );

  initial forever #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pkt[46];
  bit         bp_mode = 0;
  logic       ready_lvl = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.m_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_lvl;
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;
  logic [8:0] exp_b;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("valid_held", {31'b0, bus.m_valid}, 32'd1);
        if (bus.m_valid) begin
          check("data_stable", {24'b0, bus.m_data}, {24'b0, prev_data});
          check("last_stable", {31'b0, bus.m_last}, {31'b0, prev_last});
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", bus.m_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte_last_data", {23'b0, bus.m_last, bus.m_data}, {23'b0, exp_b});
        end
      end
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic build(input int nb, input logic [8:0] plen_v, input bit push);
    pout = '1;
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < 8; j++)
        pout[8*nb-1-(8*k+j)] = pkt[k][j];
    plen = plen_v;
    if (push)
      for (int k = 0; k < nb; k++)
        exp_q.push_back({(k == nb-1), pkt[k]});
  endtask

  task automatic set_pkt1();
    logic [7:0] p1[15] = '{8'hD6, 8'hBE, 8'h89, 8'h8E, 8'h02, 8'h06,
                           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                           8'hA1, 8'hB2, 8'hC3};
    for (int k = 0; k < 15; k++) pkt[k] = p1[k];
  endtask

  task automatic start_pkt();
    @(posedge clk);
    #1 pd = 1'b1;
  endtask

  task automatic wait_busy(input string name);
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    bit ok;
    bit busy_seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, bus.m_valid}, 32'd0);
    check("rst_last", {31'b0, bus.m_last}, 32'd0);
    check("rst_data", {24'b0, bus.m_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_counters", {16'b0, drop_cnt, err_cnt}, 32'd0);
    check("rst_hdr", {19'b0, hdr_err, pdu_type, pdu_len}, 32'd0);
    rst = 1'b1;
    en  = 1'b1;

    // Legal packet with latency check
    set_pkt1();
    build(15, 9'd128, 1);
    start_pkt();
    repeat (3) @(posedge clk);
    #1;
    check("lat_edge3_valid", {31'b0, bus.m_valid}, 32'd0);
    check("lat_edge3_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("lat_edge4_valid", {31'b0, bus.m_valid}, 32'd1);
    pd = 1'b0;
    wait_done("pkt1_done");
    check("pkt1_pdu_type", {28'b0, pdu_type}, 32'd2);
    check("pkt1_pdu_len", {24'b0, pdu_len}, 32'd6);
    check("pkt1_hdr_err", {31'b0, hdr_err}, 32'd0);
    check("pkt1_drop", {24'b0, drop_cnt}, 32'd0);

    // Backpressure
    bp_mode = 1;
    build(15, 9'd128, 1);
    start_pkt();
    wait_busy("bp_busy");
    pd = 1'b0;
    wait_done("bp_done");
    bp_mode = 0;
    repeat (2) @(posedge clk);

    // Busy drop during SEND of byte 3
    build(15, 9'd128, 1);
    start_pkt();
    wait_busy("drop_busy");
    pd = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 13) begin ok = 1; break; end
    end
    check("drop_reach_byte3", {31'b0, ok}, 32'd1);
    pd = 1'b1;
    wait_done("drop_done");
    repeat (10) @(posedge clk);
    #1;
    check("drop_count_1", {24'b0, drop_cnt}, 32'd1);
    check("drop_no_second", {31'b0, busy}, 32'd0);
    pd = 1'b0;
    repeat (4) @(posedge clk);

    // Malformed lengths
    busy_seen = 0;
    build(9, 9'd76, 0);
    start_pkt();
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (busy || bus.m_valid) busy_seen = 1; end
    pd = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (busy || bus.m_valid) busy_seen = 1; end
    plen = 9'd83;
    start_pkt();
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (busy || bus.m_valid) busy_seen = 1; end
    pd = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (busy || bus.m_valid) busy_seen = 1; end
    check("bad_len_idle", {31'b0, busy_seen}, 32'd0);
    check("err_count_2", {24'b0, err_cnt}, 32'd2);

    // Minimum size with header length mismatch
    pkt[4] = 8'h03; pkt[5] = 8'h05;
    pkt[6] = 8'hC1; pkt[7] = 8'hC2; pkt[8] = 8'hC3;
    build(9, 9'd80, 1);
    start_pkt();
    wait_busy("min_busy");
    pd = 1'b0;
    wait_done("min_done");
    check("min_pdu_type", {28'b0, pdu_type}, 32'd3);
    check("min_pdu_len", {24'b0, pdu_len}, 32'd5);
    check("min_hdr_err", {31'b0, hdr_err}, 32'd1);

    // Reset mid-SEND
    ready_lvl = 1'b0;
    set_pkt1();
    build(15, 9'd128, 0);
    start_pkt();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin ok = 1; break; end
    end
    check("rst_mid_valid_seen", {31'b0, ok}, 32'd1);
    pd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", {31'b0, bus.m_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_counters", {16'b0, drop_cnt, err_cnt}, 32'd0);
    check("rst_mid_hdr", {19'b0, hdr_err, pdu_type, pdu_len}, 32'd0);
    rst = 1'b1;
    ready_lvl = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);

    // Saturation with the block disabled
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1 pd = 1'b1;
      repeat (3) @(posedge clk);
      #1 pd = 1'b0;
      repeat (3) @(posedge clk);
      if (i == 9) begin
        #1 check("drop_count_10", {24'b0, drop_cnt}, 32'd10);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("drop_saturated", {24'b0, drop_cnt}, 32'd255);
    check("sat_busy", {31'b0, busy}, 32'd0);
    check("sat_err", {24'b0, err_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ble_packet_unloader.md
Name: ble_packet_unloader

Overview:
- Downstream stage of the BLE packet sniffer.
- Takes the captured packet vector (packet_out, packet_len) when packet_detected rises and parses the PDU header.
- Streams the packet out as bytes (access address, header, payload, CRC) in over-the-air order on a valid/ready interface toward the UART/readout logic.
- Keeps drop and error counters for the host.

Parameters:
- PACKET_LEN_MAX, 376, maximum on-air packet length in bits, preamble included.
- PREAMBLE_LEN, 8, preamble bits; these are excluded from packet_out.
- CNT_WIDTH, 8, width of the saturating status counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low; all state is cleared on a clk edge with rst=0.
- en  in  1  block enable; when 0, no new capture is started (a transfer in progress finishes).
- packet_detected  in  1  from the sniffer; asynchronous to clk and level-held.
- packet_out  in  PACKET_LEN_MAX-PREAMBLE_LEN (368)  captured bits; stable while packet_detected is high and afterwards.
- packet_len  in  9  on-air length in bits, preamble included.
- m_data  out  8  output byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  sink accepts the byte.
- m_last  out  1  marks the final byte of the packet.
- busy  out  1  high in any state other than IDLE.
- pdu_type  out  4  header byte0[3:0] of the last accepted packet.
- pdu_len  out  8  header byte1 of the last accepted packet.
- hdr_len_err  out  1  pdu_len differs from N/8-9 for the last accepted packet.
- drop_count  out  CNT_WIDTH  packets missed because the block was busy or disabled.
- err_count  out  CNT_WIDTH  packets rejected for a malformed length.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 0.
- Synchronizer: packet_detected passes through 2 flops (s1, s2), then a third flop s3. rise = s2 & ~s3.
- Bit count N = packet_len - PREAMBLE_LEN. Valid bits are packet_out[N-1:0], with the oldest bit at index N-1.
- Byte k, bit j (BLE sends LSB first) = packet_out[N-1-(8k+j)]. Byte count B = N/8.
- Length check, done in IDLE on rise: the packet is legal iff N[2:0]==0 and 72 <= N <= 368.
  - 72 bits = access address 32 + header 16 + CRC 24.
  - Illegal: err_count++ (saturating), nothing is captured, stay in IDLE.
- State machine:
  - IDLE:
    - rise & en & legal → LOAD: latch packet_out into a 368-bit buffer and N into a register.
    - rise & ~en → drop_count++, stay in IDLE.
  - LOAD (1 cycle):
    - Left-align the buffer so the oldest bit sits at bit 367.
    - Set pdu_type, pdu_len and hdr_len_err from bytes 4 and 5.
    - Set byte_idx = 0, then go to SEND.
  - SEND:
    - m_valid = 1; m_data = current byte; m_last = (byte_idx == B-1).
    - On m_valid & m_ready: advance to the next byte.
    - If m_last, go to IDLE; m_valid drops on the next cycle.
  - rise in LOAD or SEND (including the cycle of the final handshake) → drop_count++; the in-flight packet is not disturbed.
- AXI-style rules:
  - m_data and m_last hold stable while m_valid & ~m_ready.
  - m_valid never deasserts without a handshake.
  - Back-to-back bytes are supported: 1 byte/cycle when m_ready is held high.
- Latency: take the edge where s1 first samples 1 as edge 1. rise is seen after edge 2, LOAD is entered at edge 3, and m_valid goes high after edge 4.
- Counters saturate at all-ones and never wrap. They clear only on reset.
- Reset mid-transfer: the next rst=0 edge returns to IDLE, deasserts m_valid and clears the counters and header fields.
- pdu_type, pdu_len and hdr_len_err hold their values until the next accepted packet.

Test Plan:
- Legal packet: N=120, AA 0x8E89BED6, header 0x02,0x06, 6 payload bytes, 3 CRC bytes; m_ready=1 → 15 bytes D6 BE 89 8E 02 06 …; m_last on byte 15; pdu_type=2, pdu_len=6, hdr_len_err=0; m_valid high after edge 4.
- Backpressure: same packet, m_ready toggling with a random 50% duty → identical byte sequence; m_data stable while stalled; no duplicated or skipped bytes.
- Busy drop: a second packet_detected rise during SEND of byte 3 → first packet completes intact; drop_count=1; no second stream.
- Malformed length: packet_len=76 (N=68), then packet_len=83 (N not a multiple of 8) → err_count=2; m_valid stays 0; busy stays 0.
- Header mismatch and minimum size: N=72 with header byte1=0x05 → 9 bytes out; hdr_len_err=1; pdu_len=5.
- Reset and saturation: assert rst=0 mid-SEND → m_valid=0 and all counters 0 one edge later. Then 300 rises with en=0 → drop_count=255.
